// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has fixed priority, DMA port
// gets one forced slot after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [31:0]          dma_addr,
  input  logic [31:0]          dma_wdata,
  output logic                 dma_gnt,
  output logic [31:0]          dma_rdata,
  output logic                 dma_rvalid,
  output logic [CNT_WIDTH-1:0] dma_grant_count,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic {
    NORMAL,
    FORCE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 =
    CNT_WIDTH'(STARVE_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 cpu_act;
  logic                 own_cpu;
  logic                 own_dma;
  logic                 denied;
  logic                 dma_read;

  // Owner is resolved from live inputs; nobody owns the bus in reset.
  always_comb begin
    cpu_act = cpu_rd | cpu_wr;
    own_cpu = 1'b0;
    own_dma = 1'b0;
    if (rst) begin
      if (state == FORCE && dma_req)
        own_dma = 1'b1;
      else if (cpu_act)
        own_cpu = 1'b1;
      else if (dma_req)
        own_dma = 1'b1;
    end
  end

  assign denied   = rst & dma_req & ~own_dma;
  assign dma_read = own_dma & ~dma_we;

  assign dma_gnt   = own_dma;
  assign cpu_stall = own_dma & cpu_act;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = '0;
    if (own_cpu) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      cpu_rdata = mem_rdata;
    end else if (own_dma) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // FORCE never lasts more than one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= NORMAL;
      starve_cnt      <= '0;
      dma_rdata       <= '0;
      dma_rvalid      <= 1'b0;
      dma_grant_count <= '0;
    end else begin
      state      <= NORMAL;
      starve_cnt <= '0;
      if (denied) begin
        if (starve_cnt == LIMIT_M1)
          state <= FORCE;
        else
          starve_cnt <= starve_cnt + ONE;
      end
      dma_rvalid <= dma_read;
      if (dma_read)
        dma_rdata <= mem_rdata;
      if (own_dma && dma_grant_count != CNT_MAX)
        dma_grant_count <= dma_grant_count + ONE;
    end
  end

endmodule
